// File: rtl/regfile_pkg.sv
// Shared widths, channel ids and hold-entry type for the register-file writeback arbiter.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef enum logic {
        CH_ALU = 1'b0,
        CH_LSU = 1'b1
    } ch_id_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } hold_t;

    // x0 is never a real destination, so it never shows up as busy.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        if (rd != '0) oh[rd] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding buffer for a writeback channel; exposes its entry and busy contribution.
// Accepts while empty or while being granted; ready is forced low during reset.
module wb_hold_slot
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic [XLEN-1:0]     in_data,
    input  logic                grant,
    output logic                ready,
    output hold_t               hold,
    output logic [NUM_REGS-1:0] busy_vec
);

    hold_t hold_q, hold_d;
    logic  accept;

    assign ready  = !rst && (!hold_q.valid || grant);
    assign accept = in_valid && ready;

    always_comb begin
        hold_d = hold_q;
        if (grant) hold_d.valid = 1'b0;
        if (accept) begin
            hold_d.valid = 1'b1;
            hold_d.rd    = in_rd;
            hold_d.data  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end

    assign hold     = hold_q;
    assign busy_vec = hold_q.valid ? rd_onehot(hold_q.rd) : '0;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback channels onto one registered register-file write port; 2-cycle accept-to-write latency.
// Optional REGFILE_WB_TRACE_EN adds a grant-id register and simulation-only commit trace.
module regfile_wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ARB_RR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c0_valid,
    output logic                     c0_ready,
    input  logic [REG_AW-1:0]        c0_rd,
    input  logic [XLEN-1:0]          c0_data,
    input  logic                     c1_valid,
    output logic                     c1_ready,
    input  logic [REG_AW-1:0]        c1_rd,
    input  logic [XLEN-1:0]          c1_data,
    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_rd,
    output logic [XLEN-1:0]          rf_data,
    output logic [(1<<REG_AW)-1:0]   busy,
    output logic [31:0]              wb_count
);
    import regfile_pkg::*;

    hold_t               hold0, hold1, sel;
    logic [NUM_REGS-1:0] busy0, busy1;
    logic                g0, g1, gnt_any, acc0, acc1, same_rd;
    ch_id_e              pick, rr_q, rr_d, older_q, older_d;
    logic                rf_we_q, rf_we_d;
    logic [REG_AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]     rf_data_q, rf_data_d;
    logic [31:0]         wb_count_q, wb_count_d;

    wb_hold_slot u_slot0 (
        .clk(clk), .rst(rst), .in_valid(c0_valid), .in_rd(c0_rd), .in_data(c0_data),
        .grant(g0), .ready(c0_ready), .hold(hold0), .busy_vec(busy0)
    );

    wb_hold_slot u_slot1 (
        .clk(clk), .rst(rst), .in_valid(c1_valid), .in_rd(c1_rd), .in_data(c1_data),
        .grant(g1), .ready(c1_ready), .hold(hold1), .busy_vec(busy1)
    );

    assign acc0 = c0_valid && c0_ready;
    assign acc1 = c1_valid && c1_ready;

    // Same-register writes must leave in arrival order, overriding the fairness policy.
    always_comb begin
        g0      = hold0.valid;
        g1      = hold1.valid;
        pick    = CH_ALU;
        same_rd = (hold0.rd == hold1.rd) && (hold0.rd != '0);
        if (hold0.valid && hold1.valid) begin
            if (same_rd)          pick = older_q;
            else if (ARB_RR != 0) pick = rr_q;
            else                  pick = CH_ALU;
            g0 = (pick == CH_ALU);
            g1 = (pick == CH_LSU);
        end
    end

    assign gnt_any = g0 || g1;
    assign sel     = g1 ? hold1 : hold0;

    always_comb begin
        rr_d       = rr_q;
        older_d    = older_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        wb_count_d = wb_count_q + 32'(rf_we_q);
        if (g0)      rr_d = CH_LSU;
        else if (g1) rr_d = CH_ALU;
        // The entry that stays behind while the other slot fills becomes the older one.
        if (acc0 && hold1.valid && !g1)      older_d = CH_LSU;
        else if (acc1 && hold0.valid && !g0) older_d = CH_ALU;
        if (gnt_any) begin
            rf_we_d   = (sel.rd != '0);
            rf_rd_d   = sel.rd;
            rf_data_d = sel.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= CH_ALU;
            older_q    <= CH_ALU;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
            wb_count_q <= '0;
        end else begin
            rr_q       <= rr_d;
            older_q    <= older_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_data  = rf_data_q;
    assign wb_count = wb_count_q;
    assign busy     = busy0 | busy1 | (rf_we_q ? rd_onehot(rf_rd_q) : '0);

`ifdef REGFILE_WB_TRACE_EN
    ch_id_e gid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          gid_q <= CH_ALU;
        else if (gnt_any) gid_q <= g1 ? CH_LSU : CH_ALU;
    end

    always_ff @(posedge clk) begin
        if (!rst && rf_we_q)
            $display("WB ch%0d x%0d = %h", int'(gid_q), rf_rd_q, rf_data_q);
        if (!rst && gnt_any && sel.rd == '0)
            $display("WB ch%0d drop x0", g1 ? 1 : 0);
    end
`endif

endmodule
